conv_batch_scheduler: RTL and testbench

//  Sequences tensor_processing_unit over a full stride-1 KxK convolution of an IMAGE_WIDTH x IMAGE_HEIGHT map.

---
 rtl/tpu_sched_pkg.sv | 34 +++
 rtl/conv_batch_scheduler_if.sv | 36 +++
 rtl/conv_addr_walker.sv | 57 +++++
 rtl/conv_batch_scheduler.sv | 160 ++++++++++++++++
 tb/tb_conv_batch_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_sched_pkg.sv
// ---------------------------------------------------------------------------
// tpu_sched_pkg
//   Shared sizing constants, the scheduler state enum and a kernel-size
//   validity helper for conv_batch_scheduler and its address walker.
//   No ports (package).
// ---------------------------------------------------------------------------
package tpu_sched_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int IMAGE_WIDTH  = 5;
    localparam int IMAGE_HEIGHT = 5;
    localparam int NUM_UNITS    = 9;
    localparam int MEM_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW           = $clog2(MEM_SIZE);
    localparam int KD_W         = $clog2(IMAGE_WIDTH + 1);
    localparam int LEN_W        = $clog2(IMAGE_WIDTH * IMAGE_WIDTH + 1);
    localparam int LANE_W       = $clog2(NUM_UNITS);
    localparam int K_MAX        = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ARM,
        S_RUN,
        S_STORE,
        S_FINISH
    } sched_state_t;

    // A kernel must be non-empty and fit inside the map in both directions.
    function automatic logic kdim_ok(input logic [KD_W-1:0] k);
        return (k != '0) && (k <= KD_W'(K_MAX));
    endfunction

endpackage

// File: rtl/conv_batch_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv_batch_scheduler_if
//   Bundles the scheduler <-> TPU control bus and the result-memory write
//   port.
//   master : scheduler side (drives TPU controls and result writes)
//   slave  : TPU / result memory side (returns tpu_done and tpu_relu)
// ---------------------------------------------------------------------------
interface conv_batch_scheduler_if;
    import tpu_sched_pkg::*;

    logic                            tpu_start;
    logic                            tpu_read;
    logic [NUM_UNITS*AW-1:0]         tpu_addr1;
    logic [NUM_UNITS*AW-1:0]         tpu_addr2;
    logic [NUM_UNITS-1:0]            tpu_active;
    logic [KD_W-1:0]                 tpu_kdim;
    logic [LEN_W-1:0]                tpu_len;
    logic                            tpu_done;
    logic [NUM_UNITS*DATA_WIDTH-1:0] tpu_relu;
    logic                            res_we;
    logic [NUM_UNITS*AW-1:0]         res_addr;
    logic [NUM_UNITS*DATA_WIDTH-1:0] res_data;

    modport master (
        output tpu_start, tpu_read, tpu_addr1, tpu_addr2, tpu_active,
               tpu_kdim, tpu_len, res_we, res_addr, res_data,
        input  tpu_done, tpu_relu
    );

    modport slave (
        input  tpu_start, tpu_read, tpu_addr1, tpu_addr2, tpu_active,
               tpu_kdim, tpu_len, res_we, res_addr, res_data,
        output tpu_done, tpu_relu
    );

endinterface

// File: rtl/conv_addr_walker.sv
// ---------------------------------------------------------------------------
// conv_addr_walker
//   Walks output pixels row-major over an ow x oh output grid and presents
//   the current window top-left address and dense output index.
//   clk, reset : clock, synchronous active-low reset
//   clear      : restart the walk at pixel (0,0)
//   step       : advance to the next pixel (ignored once the walk is done)
//   ow, oh     : output grid width / height
//   addr       : window top-left address r*IMAGE_WIDTH + c
//   idx        : dense output index k
//   valid      : k < ow*oh, i.e. addr/idx name a real output pixel
// ---------------------------------------------------------------------------
module conv_addr_walker
    import tpu_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            step,
    input  logic [KD_W-1:0] ow,
    input  logic [KD_W-1:0] oh,
    output logic [AW-1:0]   addr,
    output logic [AW-1:0]   idx,
    output logic            valid
);

    logic [KD_W-1:0] r, c;
    logic [AW-1:0]   row_base;   // r*IMAGE_WIDTH, kept incrementally
    logic [AW-1:0]   k;

    // Running out of rows is equivalent to k reaching ow*oh, so no
    // product of the grid dimensions is ever formed.
    assign valid = (r < oh);
    assign addr  = row_base + AW'(c);
    assign idx   = k;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r        <= '0;
            c        <= '0;
            row_base <= '0;
            k        <= '0;
        end else if (step && valid) begin
            // NOTE: non-blocking assignments keep every register update
            // based on pre-edge values, so r/c/row_base stay consistent.
            k <= k + AW'(1);
            if (c == ow - KD_W'(1)) begin
                c        <= '0;
                r        <= r + KD_W'(1);
                row_base <= row_base + AW'(IMAGE_WIDTH);
            end else begin
                c <= c + KD_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_batch_scheduler.sv
// ---------------------------------------------------------------------------
// conv_batch_scheduler
//   Runs a full stride-1 KxK convolution on the TPU in batches of NUM_UNITS
//   output pixels: programs per-lane window addresses, starts the TPU, and
//   writes each batch's relu vector to the result memory.
//   clk, reset : clock, synchronous active-low reset
//   go         : start request (sampled in IDLE only)
//   cfg_kdim   : kernel dimension K, latched on an accepted go
//   busy       : accepted go through the FINISH cycle
//   conv_done  : 1-cycle pulse in FINISH
//   cfg_err    : 1-cycle pulse for a rejected go
//   bus        : TPU control + result write port (master side)
// ---------------------------------------------------------------------------
module conv_batch_scheduler
    import tpu_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [KD_W-1:0]        cfg_kdim,
    output logic                   busy,
    output logic                   conv_done,
    output logic                   cfg_err,
    conv_batch_scheduler_if.master bus
);

    sched_state_t state;
    logic [LANE_W-1:0] lane;
    logic [KD_W-1:0]   kdim_q;
    logic [LEN_W-1:0]  len_q;
    logic              start_q, read_q, we_q;

    logic [NUM_UNITS-1:0]                 active_q;
    logic [NUM_UNITS-1:0][AW-1:0]         addr1_q;
    logic [NUM_UNITS-1:0][AW-1:0]         raddr_q;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] rdata_q;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] relu_v;

    logic            w_clear, w_step, w_valid;
    logic [AW-1:0]   w_addr, w_idx;
    logic [KD_W-1:0] ow, oh;

    assign ow      = KD_W'(IMAGE_WIDTH + 1) - kdim_q;
    assign oh      = KD_W'(IMAGE_HEIGHT + 1) - kdim_q;
    assign w_clear = (state == S_IDLE) && go && kdim_ok(cfg_kdim);
    assign w_step  = (state == S_SETUP);
    assign relu_v  = bus.tpu_relu;

    conv_addr_walker u_walker (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .step  (w_step),
        .ow    (ow),
        .oh    (oh),
        .addr  (w_addr),
        .idx   (w_idx),
        .valid (w_valid)
    );

    assign bus.tpu_start  = start_q;
    assign bus.tpu_read   = read_q;
    assign bus.tpu_addr1  = addr1_q;
    assign bus.tpu_addr2  = '0;          // kernel always sits at base 0
    assign bus.tpu_active = active_q;
    assign bus.tpu_kdim   = kdim_q;
    assign bus.tpu_len    = len_q;
    assign bus.res_we     = we_q;
    assign bus.res_addr   = raddr_q;
    assign bus.res_data   = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the lane register files are small and drive outputs
            // directly, so they are reset to give all-zero outputs.
            state     <= S_IDLE;
            lane      <= '0;
            kdim_q    <= '0;
            len_q     <= '0;
            start_q   <= 1'b0;
            read_q    <= 1'b0;
            we_q      <= 1'b0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
            cfg_err   <= 1'b0;
            active_q  <= '0;
            addr1_q   <= '0;
            raddr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            conv_done <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (kdim_ok(cfg_kdim)) begin
                            kdim_q <= cfg_kdim;
                            len_q  <= LEN_W'(cfg_kdim) * LEN_W'(cfg_kdim);
                            busy   <= 1'b1;
                            lane   <= '0;
                            state  <= S_SETUP;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (w_valid) begin
                        addr1_q[lane]  <= w_addr;
                        raddr_q[lane]  <= w_idx;
                        active_q[lane] <= 1'b1;
                    end else begin
                        // Lane 0 is always live in a batch; shadowing it makes
                        // an ungated write of an idle lane a harmless rewrite.
                        addr1_q[lane]  <= '0;
                        raddr_q[lane]  <= raddr_q[0];
                        active_q[lane] <= 1'b0;
                    end
                    if (lane == LANE_W'(NUM_UNITS - 1)) begin
                        read_q <= 1'b1;
                        state  <= S_ARM;
                    end else begin
                        lane <= lane + LANE_W'(1);
                    end
                end
                S_ARM: begin
                    start_q <= 1'b1;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (bus.tpu_done) begin
                        start_q <= 1'b0;
                        read_q  <= 1'b0;
                        we_q    <= 1'b1;
                        for (int u = 0; u < NUM_UNITS; u++) begin
                            rdata_q[u] <= active_q[u] ? relu_v[u] : relu_v[0];
                        end
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    we_q <= 1'b0;
                    lane <= '0;
                    if (w_valid) begin
                        state <= S_SETUP;
                    end else begin
                        conv_done <= 1'b1;
                        state     <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_batch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_batch_scheduler
//   Directed bench for conv_batch_scheduler: a table of kernel sizes and TPU
//   latencies with hand-computed batch counts, masks and lengths, plus
//   sequences for mid-run reset and ignored go/tpu_done pulses.
// ---------------------------------------------------------------------------
module tb_conv_batch_scheduler;
    import tpu_sched_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            go = 1'b0;
    logic [KD_W-1:0] cfg_kdim = '0;
    logic            busy, conv_done, cfg_err;

    int n_vec = 0;
    int n_err = 0;

    conv_batch_scheduler_if bif();

    conv_batch_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .cfg_kdim  (cfg_kdim),
        .busy      (busy),
        .conv_done (conv_done),
        .cfg_err   (cfg_err),
        .bus       (bif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KD_W-1:0]      kdim;
        int                   lat;          // cycles from start to done
        bit                   err;          // go must be rejected
        int                   batches;
        logic [NUM_UNITS-1:0] last_active;  // mask of the final batch
        int                   len;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        go    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_err(input vec_t v);
        bit seen_start, seen_busy, seen_err;
        @(negedge clk);
        cfg_kdim = v.kdim;
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check($sformatf("err_pulse k%0d", v.kdim), cfg_err, 1);
        check($sformatf("err_busy k%0d", v.kdim), busy, 0);
        seen_start = 0; seen_busy = 0; seen_err = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            seen_start |= bif.tpu_start;
            seen_busy  |= busy;
            seen_err   |= cfg_err;
        end
        check($sformatf("err_quiet k%0d", v.kdim), {29'd0, seen_start, seen_busy, seen_err}, 0);
    endtask

    // Runs a whole convolution; the address walk is re-derived here from
    // r/c loops over the output grid.
    task automatic run_conv(input vec_t v, input bit perturb);
        int ow, n, mk, mr, mc;
        bit ok, prev_read, last;
        logic [AW-1:0]         ea [NUM_UNITS];
        logic [AW-1:0]         ei [NUM_UNITS];
        logic [DATA_WIDTH-1:0] rd [NUM_UNITS];
        logic [NUM_UNITS-1:0]  exp_act;
        string tag;

        ow = IMAGE_WIDTH - int'(v.kdim) + 1;
        n  = ow * (IMAGE_HEIGHT - int'(v.kdim) + 1);
        mk = 0; mr = 0; mc = 0;

        @(negedge clk);
        cfg_kdim = v.kdim;
        go       = 1'b1;
        @(negedge clk);
        go       = 1'b0;
        cfg_kdim = '0;      // K must already be latched
        check($sformatf("go_busy k%0d", v.kdim), busy, 1);
        check($sformatf("go_noerr k%0d", v.kdim), cfg_err, 0);

        for (int b = 0; b < v.batches; b++) begin
            tag  = $sformatf("k%0d l%0d b%0d", v.kdim, v.lat, b);
            last = (b == v.batches - 1);
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (mk < n) begin
                    ea[u] = AW'(mr * IMAGE_WIDTH + mc);
                    ei[u] = AW'(mk);
                    mk++;
                    if (mc == ow - 1) begin mc = 0; mr++; end
                    else mc++;
                end else begin
                    ea[u] = '0;
                    ei[u] = ei[0];
                end
            end

            ok = 0; prev_read = 0;
            for (int t = 0; t < 40; t++) begin
                if (bif.tpu_start) begin ok = 1; break; end
                if (perturb && b == 0 && t == 3) begin
                    go = 1'b1; bif.tpu_done = 1'b1;
                end else begin
                    go = 1'b0; bif.tpu_done = 1'b0;
                end
                prev_read = bif.tpu_read;
                @(negedge clk);
            end
            go = 1'b0;
            bif.tpu_done = 1'b0;
            if (!ok) begin
                check({"start_timeout ", tag}, 0, 1);
                do_reset();
                return;
            end

            exp_act = last ? v.last_active : {NUM_UNITS{1'b1}};
            check({"arm_read ", tag}, prev_read, 1);
            check({"run_read ", tag}, bif.tpu_read, 1);
            check({"kdim ", tag}, bif.tpu_kdim, v.kdim);
            check({"len ", tag}, bif.tpu_len, v.len);
            check({"active ", tag}, bif.tpu_active, exp_act);
            check({"addr2 ", tag}, {31'd0, |bif.tpu_addr2}, 0);
            for (int u = 0; u < NUM_UNITS; u++) begin
                check($sformatf("addr1[%0d] %s", u, tag), bif.tpu_addr1[u*AW +: AW], ea[u]);
                rd[u] = exp_act[u] ? DATA_WIDTH'(32'hA000 | (u << 8) | int'(ea[u]))
                                   : DATA_WIDTH'(32'h5A00 | u);
                bif.tpu_relu[u*DATA_WIDTH +: DATA_WIDTH] = rd[u];
            end

            if (v.lat > 0) begin
                repeat (v.lat) @(negedge clk);
                check({"run_hold ", tag}, bif.tpu_start, 1);
            end
            bif.tpu_done = 1'b1;
            @(negedge clk);
            bif.tpu_done = 1'b0;
            bif.tpu_relu = '0;

            check({"store_we ", tag}, bif.res_we, 1);
            check({"store_start ", tag}, bif.tpu_start, 0);
            for (int u = 0; u < NUM_UNITS; u++) begin
                check($sformatf("res_addr[%0d] %s", u, tag), bif.res_addr[u*AW +: AW], ei[u]);
                check($sformatf("res_data[%0d] %s", u, tag), bif.res_data[u*DATA_WIDTH +: DATA_WIDTH],
                      exp_act[u] ? rd[u] : rd[0]);
            end

            @(negedge clk);
            check({"post_we ", tag}, bif.res_we, 0);
            check({"post_done ", tag}, conv_done, last);
            check({"post_busy ", tag}, busy, 1);
        end
        @(negedge clk);
        check($sformatf("idle_busy k%0d", v.kdim), busy, 0);
        check($sformatf("idle_done k%0d", v.kdim), conv_done, 0);
    endtask

    logic [AW-1:0] k2_b0 [NUM_UNITS];
    vec_t          v_k2;
    bit            ok;

    initial begin
        bif.tpu_done = 1'b0;
        bif.tpu_relu = '0;

        //         kdim lat err batches last_active len
        vecs[0] = '{3'd3,  0, 0, 1, 9'h1FF,  9};
        vecs[1] = '{3'd2,  0, 0, 2, 9'h07F,  4};
        vecs[2] = '{3'd2, 20, 0, 2, 9'h07F,  4};
        vecs[3] = '{3'd5,  3, 0, 1, 9'h001, 25};
        vecs[4] = '{3'd1,  1, 0, 3, 9'h07F,  1};
        vecs[5] = '{3'd4,  2, 0, 1, 9'h00F, 16};
        vecs[6] = '{3'd0,  0, 1, 0, 9'h000,  0};
        vecs[7] = '{3'd6,  0, 1, 0, 9'h000,  0};
        vecs[8] = '{3'd7,  0, 1, 0, 9'h000,  0};

        k2_b0 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10};

        repeat (2) @(negedge clk);
        check("rst_ctrl", {29'd0, busy, conv_done, cfg_err}, 0);
        check("rst_tpu", {29'd0, bif.tpu_start, bif.tpu_read, |bif.tpu_active}, 0);
        check("rst_addr1", {31'd0, |bif.tpu_addr1}, 0);
        check("rst_res", {30'd0, bif.res_we, |{bif.res_addr, bif.res_data}}, 0);
        check("rst_cfg", {31'd0, |{bif.tpu_kdim, bif.tpu_len}}, 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].err) run_err(vecs[i]);
            else             run_conv(vecs[i], 1'b0);
        end

        // Reset while batch 0 of a K=2 run is in RUN.
        @(negedge clk);
        cfg_kdim = 3'd2;
        go       = 1'b1;
        @(negedge clk);
        go = 1'b0;
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            if (bif.tpu_start) begin ok = 1; break; end
            @(negedge clk);
        end
        check("mid_start_seen", ok, 1);
        for (int u = 0; u < NUM_UNITS; u++)
            check($sformatf("k2_b0_addr1[%0d]", u), bif.tpu_addr1[u*AW +: AW], k2_b0[u]);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ctrl", {29'd0, busy, conv_done, cfg_err}, 0);
        check("mid_rst_tpu", {29'd0, bif.tpu_start, bif.tpu_read, |bif.tpu_active}, 0);
        check("mid_rst_bus", {30'd0, bif.res_we, |{bif.tpu_addr1, bif.res_addr, bif.tpu_kdim}}, 0);
        reset = 1'b1;

        v_k2     = vecs[1];
        v_k2.lat = 1;
        run_conv(v_k2, 1'b0);   // fresh go restarts from address 0
        run_conv(vecs[1], 1'b1); // go and tpu_done pulsed during SETUP

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
